// File: rtl/matrix_8_8_sequencer_if.sv
// Bus bundle between the element source, the Matrix_8_8 row store and the
// downstream DCT stage. The master modport is the sequencer's view.
interface matrix_8_8_sequencer_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    // element stream in
    logic                in_valid;
    logic                in_ready;
    logic [DATA_W-1:0]   in_data;

    // Matrix_8_8 row store port
    logic [DATA_W-1:0]   W0, W1, W2, W3, W4, W5, W6, W7;
    logic [ADDR_W-1:0]   address;
    logic                rw;
    logic [DATA_W-1:0]   R0, R1, R2, R3, R4, R5, R6, R7;

    // vector stream out
    logic                out_valid;
    logic                out_ready;
    logic [8*DATA_W-1:0] out_data;
    logic [2:0]          out_index;
    logic                out_last;

    modport master (
        input  in_valid, in_data,
        output in_ready,
        output W0, W1, W2, W3, W4, W5, W6, W7, address, rw,
        input  R0, R1, R2, R3, R4, R5, R6, R7,
        output out_valid, out_data, out_index, out_last,
        input  out_ready
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready,
        input  W0, W1, W2, W3, W4, W5, W6, W7, address, rw,
        output R0, R1, R2, R3, R4, R5, R6, R7,
        input  out_valid, out_data, out_index, out_last,
        output out_ready
    );
endinterface

// File: rtl/matrix_8_8_sequencer.sv
// Matrix_8_8 initiator: packs a serial element stream into 8-element rows,
// writes an 8x8 block into the row store, then reads it back as eight
// 8-word vectors for the DCT stage.
// Build option: define MATRIX_SEQ_TRANSPOSE_EN to read the block back as
// columns (transpose); leave it undefined to read it back as rows.
module matrix_8_8_sequencer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    matrix_8_8_sequencer_if.master   bus
);

`ifdef MATRIX_SEQ_TRANSPOSE_EN
    // column addresses 8-15 return one element from every row
    localparam logic [ADDR_W-1:0] RD_BASE = ADDR_W'(8);
`else
    // row addresses 0-7 return the rows as written
    localparam logic [ADDR_W-1:0] RD_BASE = ADDR_W'(0);
`endif

    typedef enum logic [2:0] {
        FILL   = 3'd0,
        WR     = 3'd1,
        RD_REQ = 3'd2,
        RD_CAP = 3'd3,
        EMIT   = 3'd4
    } state_t;

    state_t            state;
    logic [2:0]        col;
    logic [2:0]        row;
    logic [2:0]        rd;
    logic [DATA_W-1:0] row_buf [8];

    // Row buffer doubles as the W0..W7 output register; rw is only high in WR
    assign bus.W0 = row_buf[0];
    assign bus.W1 = row_buf[1];
    assign bus.W2 = row_buf[2];
    assign bus.W3 = row_buf[3];
    assign bus.W4 = row_buf[4];
    assign bus.W5 = row_buf[5];
    assign bus.W6 = row_buf[6];
    assign bus.W7 = row_buf[7];

    // Sequencer FSM; in_ready/rw/address are registered alongside the state
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= FILL;
            col           <= 3'd0;
            row           <= 3'd0;
            rd            <= 3'd0;
            for (int k = 0; k < 8; k++) begin
                row_buf[k] <= '0;
            end
            bus.in_ready  <= 1'b0;
            bus.rw        <= 1'b0;
            bus.address   <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_index <= 3'd0;
            bus.out_last  <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    bus.in_ready <= 1'b1;
                    if (bus.in_valid && bus.in_ready) begin
                        row_buf[col] <= bus.in_data;
                        if (col == 3'd7) begin
                            state        <= WR;
                            bus.in_ready <= 1'b0;
                            bus.rw       <= 1'b1;
                            bus.address  <= ADDR_W'(row);
                        end else begin
                            col <= col + 3'd1;
                        end
                    end
                end

                WR: begin
                    bus.rw <= 1'b0;
                    col    <= 3'd0;
                    row    <= row + 3'd1;
                    if (row == 3'd7) begin
                        state       <= RD_REQ;
                        rd          <= 3'd0;
                        bus.address <= RD_BASE;
                    end else begin
                        state        <= FILL;
                        bus.address  <= '0;
                        bus.in_ready <= 1'b1;
                    end
                end

                RD_REQ: begin
                    state       <= RD_CAP;
                    bus.address <= '0;
                end

                RD_CAP: begin
                    bus.out_data  <= {bus.R7, bus.R6, bus.R5, bus.R4,
                                      bus.R3, bus.R2, bus.R1, bus.R0};
                    bus.out_index <= rd;
                    bus.out_last  <= (rd == 3'd7);
                    bus.out_valid <= 1'b1;
                    state         <= EMIT;
                end

                EMIT: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        if (rd == 3'd7) begin
                            state        <= FILL;
                            row          <= 3'd0;
                            bus.in_ready <= 1'b1;
                        end else begin
                            rd          <= rd + 3'd1;
                            state       <= RD_REQ;
                            bus.address <= RD_BASE + ADDR_W'(rd + 3'd1);
                        end
                    end
                end

                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

endmodule
